// File: rtl/mem_if_pkg.sv
// Shared definitions for the memory-access initiator slice.
// Holds the access FSM state encoding and the default geometry/latency
// parameters used by mem_access_initiator and its latency counter.
package mem_if_pkg;

    localparam int unsigned ADDR_W_DEF = 9;   // 512-word RAM
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned RD_LAT_DEF = 1;   // cycles mem_read held before capture

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_WR,
        ST_CAPTURE,
        ST_DONE
    } mem_state_t;

endpackage

// File: rtl/mem_lat_counter.sv
// Read-latency down counter.
// Ports:
//   clock       in   rising-edge clock
//   clear       in   asynchronous active-high reset (count -> 0)
//   load        in   load load_value (has priority over dec)
//   load_value  in   W-bit start value
//   dec         in   decrement by one (saturates at zero)
//   zero        out  count == 0
module mem_lat_counter #(
    parameter int unsigned W = 1
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_access_initiator.sv
// Bus-master end of the memory-subsystem interface. Turns one-shot load/store
// requests into MAR/MDR/RAM strobes, captures load data and reports completion
// with a one-cycle done pulse (err flags an out-of-range address).
// Ports:
//   clock, clear          clock / asynchronous active-high reset
//   start, is_store       request strobe and direction (sampled when ready=1)
//   addr, wdata           request word address and store data
//   ready                 high in IDLE only
//   done, err             completion pulse, err valid with done
//   rdata                 data of the last successful load
//   mem_address           MAR to RAM
//   mem_read, mem_write   RAM strobes
//   mem_wdata             MDR to RAM
//   mem_rdata             RAM read data
module mem_access_initiator
    import mem_if_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned RD_LAT = RD_LAT_DEF
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic              is_store,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);

    mem_state_t        state, next_state;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mdr;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              out_of_range;
    logic              accept;
    logic              cnt_load, cnt_dec, cnt_zero;

    // Any set bit above the RAM word range makes the request invalid.
    assign out_of_range = ((addr >> ADDR_W) != 32'd0);
    assign accept       = (state == ST_IDLE) && start;

    mem_lat_counter #(.W(CNT_W)) u_lat_counter (
        .clock      (clock),
        .clear      (clear),
        .load       (cnt_load),
        .load_value (CNT_INIT),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // rdata is kept apart from MDR so stores and errored requests, which
    // also load MDR, never disturb the last load result.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            mar     <= '0;
            mdr     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                mar   <= addr[ADDR_W-1:0];
                err_q <= out_of_range;
                if (is_store) begin
                    mdr <= wdata;
                end
            end
            if (state == ST_CAPTURE) begin
                mdr     <= mem_rdata;
                rdata_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        next_state = state;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    if (out_of_range) begin
                        next_state = ST_DONE;
                    end else if (is_store) begin
                        next_state = ST_WR;
                    end else begin
                        next_state = ST_RD_WAIT;
                        cnt_load   = 1'b1;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (cnt_zero) begin
                    next_state = ST_CAPTURE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_WR:      next_state = ST_DONE;
            ST_CAPTURE: next_state = ST_DONE;
            ST_DONE:    next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    assign ready       = (state == ST_IDLE);
    assign done        = (state == ST_DONE);
    assign err         = (state == ST_DONE) && err_q;
    assign mem_read    = (state == ST_RD_WAIT) || (state == ST_CAPTURE);
    assign mem_write   = (state == ST_WR);
    assign mem_address = mar;
    assign mem_wdata   = mdr;
    assign rdata       = rdata_q;

endmodule

// File: tb/tb_mem_access_initiator.sv
// Bench for mem_access_initiator: two instances (RD_LAT=1 and RD_LAT=3) share
// one request stream; each has its own RAM. Expected timing and data come from
// a request-level model (latency formulas plus an expected-memory array).
module tb_mem_access_initiator;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 32;

    logic          clock = 1'b0;
    logic          clear;
    logic          start;
    logic          is_store;
    logic [31:0]   addr;
    logic [DW-1:0] wdata;

    logic          ready_a, done_a, err_a, mem_read_a, mem_write_a;
    logic [DW-1:0] rdata_a, mem_wdata_a, mem_rdata_a;
    logic [AW-1:0] mem_address_a;
    logic          ready_b, done_b, err_b, mem_read_b, mem_write_b;
    logic [DW-1:0] rdata_b, mem_wdata_b, mem_rdata_b;
    logic [AW-1:0] mem_address_b;

    logic [DW-1:0] ram_a [512];
    logic [DW-1:0] ram_b [512];
    logic [DW-1:0] model_mem [512];
    logic [DW-1:0] model_rdata;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clock = ~clock;

    mem_access_initiator #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut_a (
        .clock(clock), .clear(clear), .start(start), .is_store(is_store),
        .addr(addr), .wdata(wdata), .ready(ready_a), .done(done_a), .err(err_a),
        .rdata(rdata_a), .mem_address(mem_address_a), .mem_read(mem_read_a),
        .mem_write(mem_write_a), .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a)
    );

    mem_access_initiator #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut_b (
        .clock(clock), .clear(clear), .start(start), .is_store(is_store),
        .addr(addr), .wdata(wdata), .ready(ready_b), .done(done_b), .err(err_b),
        .rdata(rdata_b), .mem_address(mem_address_b), .mem_read(mem_read_b),
        .mem_write(mem_write_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
    );

    // RAM models: asynchronous read, synchronous write.
    assign mem_rdata_a = ram_a[mem_address_a];
    assign mem_rdata_b = ram_b[mem_address_b];
    always @(posedge clock) begin
        if (mem_write_a) ram_a[mem_address_a] <= mem_wdata_a;
        if (mem_write_b) ram_b[mem_address_b] <= mem_wdata_b;
    end

    // Per-instance views so both DUTs are checked by the same loop.
    logic          s_rdy [2], s_done [2], s_err [2], s_rd [2], s_wr [2];
    logic [AW-1:0] s_ma [2];
    logic [DW-1:0] s_wd [2], s_rdata [2];
    assign s_rdy[0] = ready_a;        assign s_rdy[1] = ready_b;
    assign s_done[0] = done_a;        assign s_done[1] = done_b;
    assign s_err[0] = err_a;          assign s_err[1] = err_b;
    assign s_rd[0] = mem_read_a;      assign s_rd[1] = mem_read_b;
    assign s_wr[0] = mem_write_a;     assign s_wr[1] = mem_write_b;
    assign s_ma[0] = mem_address_a;   assign s_ma[1] = mem_address_b;
    assign s_wd[0] = mem_wdata_a;     assign s_wd[1] = mem_wdata_b;
    assign s_rdata[0] = rdata_a;      assign s_rdata[1] = rdata_b;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One request; noisy keeps start high with junk requests while busy and
    // through the first DONE cycle, which must all be ignored.
    task automatic do_req(input bit st, input logic [31:0] a, input logic [DW-1:0] d,
                          input bit noisy);
        bit            exp_err;
        logic [DW-1:0] exp_rdata;
        int            done_at [2];
        int            rdc [2];
        int            wrc [2];
        int            first_rd [2];
        int            exp_done;
        exp_err   = ((a >> AW) != 0);
        exp_rdata = (!exp_err && !st) ? model_mem[a[AW-1:0]] : model_rdata;
        for (int k = 0; k < 2; k++) begin
            done_at[k] = 0; rdc[k] = 0; wrc[k] = 0; first_rd[k] = 0;
        end

        @(negedge clock);
        start = 1'b1; is_store = st; addr = a; wdata = d;
        @(posedge clock); #1;
        if (noisy) begin
            is_store = $urandom_range(0, 1);
            addr     = $urandom_range(0, 511);
            wdata    = $urandom;
        end else begin
            start = 1'b0;
        end

        for (int c = 1; c <= 16; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (done_at[k] == 0) begin
                    if (c == 1) check("ready_busy", s_rdy[k], 1'b0);
                    check("strobe_excl", s_rd[k] & s_wr[k], 1'b0);
                    if (s_rd[k] || s_wr[k]) check("mem_address", s_ma[k], a[AW-1:0]);
                    if (s_wr[k]) check("mem_wdata", s_wd[k], d);
                    if (s_rd[k]) begin
                        rdc[k]++;
                        if (first_rd[k] == 0) first_rd[k] = c;
                    end
                    if (s_wr[k]) wrc[k]++;
                    if (s_done[k]) begin
                        done_at[k] = c;
                        check("err", s_err[k], exp_err);
                        check("rdata", s_rdata[k], exp_rdata);
                    end
                end else begin
                    // Finished instance must stay idle despite any start noise.
                    check("idle_after_done", {s_rdy[k], s_done[k], s_rd[k], s_wr[k]}, 4'b1000);
                end
            end
            if (done_at[0] != 0 && done_at[1] != 0) break;
            @(posedge clock); #1;
            if (done_at[0] != 0) start = 1'b0;
        end

        for (int k = 0; k < 2; k++) begin
            exp_done = exp_err ? 1 : (st ? 2 : lat_of(k) + 2);
            check("done_seen", done_at[k] != 0, 1'b1);
            check("done_cycle", done_at[k], exp_done);
            check("read_cycles", rdc[k], (!exp_err && !st) ? lat_of(k) + 1 : 0);
            check("write_cycles", wrc[k], (!exp_err && st) ? 1 : 0);
            if (rdc[k] != 0) check("first_read_cycle", first_rd[k], 1);
        end

        @(posedge clock); #1;
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("ready_after", {s_rdy[k], s_done[k]}, 2'b10);
            check("rdata_hold", s_rdata[k], exp_rdata);
        end

        if (!exp_err && st) model_mem[a[AW-1:0]] = d;
        model_rdata = exp_rdata;
    endtask

    initial begin
        logic [31:0] ra;
        logic [DW-1:0] rd;
        for (int i = 0; i < 512; i++) begin
            ra = i * 32'h9E37_79B9 ^ 32'h5A5A_0000;
            ram_a[i] = ra; ram_b[i] = ra; model_mem[i] = ra;
        end
        ram_a[9'h1FF] = 32'h1234_5678;
        ram_b[9'h1FF] = 32'h1234_5678;
        model_mem[9'h1FF] = 32'h1234_5678;
        model_rdata = '0;

        clear = 1'b1; start = 1'b0; is_store = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        clear = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("reset_ctrl", {s_rdy[k], s_done[k], s_err[k], s_rd[k], s_wr[k]}, 5'b10000);
            check("reset_addr", s_ma[k], '0);
            check("reset_wdata", s_wd[k], '0);
            check("reset_rdata", s_rdata[k], '0);
        end

        // Clear asserted while a load is waiting on RAM.
        @(negedge clock);
        start = 1'b1; is_store = 1'b0; addr = 32'h1FF;
        @(posedge clock); #1;
        start = 1'b0;
        for (int k = 0; k < 2; k++) check("midload_read", s_rd[k], 1'b1);
        clear = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("clear_ctrl", {s_rdy[k], s_done[k], s_rd[k], s_wr[k]}, 4'b1000);
            check("clear_rdata", s_rdata[k], '0);
        end
        @(negedge clock);
        clear = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clock); #1;
            for (int k = 0; k < 2; k++) check("no_done_after_clear", {s_rdy[k], s_done[k]}, 2'b10);
        end
        model_rdata = '0;

        // Directed requests.
        do_req(1'b1, 32'h0000_0005, 32'hDEAD_BEEF, 1'b0);
        do_req(1'b0, 32'h0000_01FF, '0, 1'b0);
        do_req(1'b0, 32'h0000_0200, '0, 1'b0);
        do_req(1'b1, 32'h8000_0000, 32'hCAFE_F00D, 1'b0);
        do_req(1'b0, 32'h0000_0005, '0, 1'b0);
        do_req(1'b1, 32'h0000_0000, 32'h0BAD_CAFE, 1'b1);
        do_req(1'b0, 32'h0000_0000, '0, 1'b1);
        do_req(1'b0, 32'hFFFF_FFFF, '0, 1'b1);

        // Randomised requests, back-to-back.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) ra = $urandom | 32'h0000_0200;
            else ra = $urandom_range(0, 511);
            rd = $urandom;
            do_req(1'($urandom_range(0, 1)), ra, rd, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
